// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer.
//   DATA_W_DEF : default character width (must match the transmitter)
//   ADDR_W_DEF : default FIFO address width, depth = 2**ADDR_W_DEF
//   tx_state_t : launcher FSM state (IDLE = ready to pop, WAIT = char in flight)
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Parameterised synchronous FIFO, first-word-fall-through read.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   push, din     : enqueue request and data (ignored when full or flushing)
//   pop           : dequeue request (ignored when empty or flushing)
//   flush         : synchronous clear, read pointer jumps to write pointer
//   dout          : head entry, valid whenever empty = 0
//   full, empty   : occupancy flags, decoded from registered pointers only
//   count         : occupancy, 0 .. 2**ADDR_W
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once they have been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[ADDR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buf.sv
// Transmit buffer feeding a UART transmitter one byte at a time.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en, wr_data    : host write, one byte per cycle
//   flush             : drop all queued bytes (an in-flight byte still completes)
//   clr_ovf           : clear the sticky overflow flag
//   full, empty, count: FIFO occupancy
//   overflow          : sticky, a write arrived while full and was dropped
//   tx_start, tx_din  : one-cycle launch pulse and registered byte to transmitter
//   tx_done_tick      : completion pulse from transmitter
//   busy              : a character is in flight
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_din,
    input  logic              tx_done_tick,
    output logic              busy
);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              pop_go;
    logic [DATA_W-1:0] head;

    uart_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop_go),
        .flush (flush),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Launch only from IDLE; a flush in the same cycle cancels the would-be pop.
    // tx_done_tick is only meaningful in WAIT.
    always_comb begin
        state_nxt = state;
        pop_go    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop_go    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (tx_done_tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx_start follows the pop by one edge, so it is high for exactly one cycle
    // (the FSM is in WAIT on the following edge). tx_din holds until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= pop_go;
            if (pop_go) tx_din <= head;
        end
    end

    // Set beats clear when a dropped write coincides with clr_ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               overflow <= 1'b0;
        else if (wr_en && full)  overflow <= 1'b1;
        else if (clr_ovf)        overflow <= 1'b0;
    end

    assign busy = (state == WAIT);

endmodule
